// File: rtl/instr_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the instruction-fetch stage:
//   - fetch_state_t : fetch FSM state encoding (IDLE / ISSUE / WAIT / DONE)
//   - INSTR_W       : instruction word width
//   - NOP_WORD_DEFAULT : word loaded into IR when a fetch times out
// ---------------------------------------------------------------------------
package instr_fetch_unit_pkg;

    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

endpackage : instr_fetch_unit_pkg

// File: rtl/instr_fetch_unit_pc_reg.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_pc_reg
// Program counter register. A branch/jump load takes priority over the
// increment; the increment wraps modulo 2^ADDR_W.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (pc <= RESET_PC)
//   pc_inc     : pc <= pc + 1
//   pc_load    : pc <= pc_target (wins over pc_inc)
//   pc_target  : branch/jump destination
//   pc         : current program counter
// ---------------------------------------------------------------------------
module instr_fetch_unit_pc_reg #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_inc,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;

    always_comb begin
        pc_next = pc_reg;
        if (pc_load) begin
            pc_next = pc_target;
        end else if (pc_inc) begin
            // Natural overflow of the ADDR_W-bit add gives the wrap to 0.
            pc_next = pc_reg + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;

endmodule : instr_fetch_unit_pc_reg

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Instruction-fetch stage: owns the PC, reads instruction memory over a
// req/ack handshake and latches the returned word into the IR for the
// control FSM. A fetch that sees no ack within MAX_WAIT wait cycles loads
// NOP_WORD and raises a sticky error flag.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   fetch_req           : pulse, fetch the word at the current PC
//   pc_inc, pc_load     : PC increment / load commands from control FSM
//   pc_target           : PC load value
//   mem_addr, mem_rd    : memory read address and request (held until ack)
//   mem_ack, mem_rdata  : memory response
//   ir, ir_valid        : instruction register and its one-cycle valid pulse
//   pc                  : current program counter
//   busy                : fetch in progress
//   fetch_err           : sticky timeout flag
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 MAX_WAIT = 15,
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_req,
    input  logic               pc_inc,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_target,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               fetch_err
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

    fetch_state_t       state_reg;
    fetch_state_t       state_next;
    logic [ADDR_W-1:0]  fetch_addr_reg;
    logic [INSTR_W-1:0] ir_reg;
    logic [WAIT_W-1:0]  wait_cnt_reg;
    logic               fetch_err_reg;
    logic               wait_timeout;

    // Last permitted wait cycle passed without an ack.
    assign wait_timeout = (state_reg == ST_WAIT) && !mem_ack && (wait_cnt_reg == LAST_WAIT);

    // -----------------------------------------------------------------------
    // PC: updates every cycle regardless of fetch state. An in-flight fetch
    // is unaffected because it reads from fetch_addr_reg.
    // -----------------------------------------------------------------------
    instr_fetch_unit_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .pc        (pc)
    );

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (fetch_req) state_next = ST_ISSUE;
            ST_ISSUE: state_next = mem_ack ? ST_DONE : ST_WAIT;
            ST_WAIT:  if (mem_ack || wait_timeout) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: Moore output decode. Being pure state decodes, mem_rd and busy
    // fall as soon as the asynchronous reset clears the state register.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_rd   = 1'b0;
        busy     = 1'b1;
        ir_valid = 1'b0;
        case (state_reg)
            ST_IDLE:  busy     = 1'b0;
            ST_ISSUE: mem_rd   = 1'b1;
            ST_WAIT:  mem_rd   = 1'b1;
            ST_DONE:  ir_valid = 1'b1;
            default:  busy     = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Fetch datapath: address latch, IR capture, wait counter, error flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_addr_reg <= RESET_PC;
            ir_reg         <= '0;
            wait_cnt_reg   <= '0;
            fetch_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (fetch_req) fetch_addr_reg <= pc;
                end
                ST_ISSUE: begin
                    wait_cnt_reg <= '0;
                    if (mem_ack) ir_reg <= mem_rdata;
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        ir_reg <= mem_rdata;
                    end else if (wait_timeout) begin
                        ir_reg        <= NOP_WORD;
                        fetch_err_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr  = fetch_addr_reg;
    assign ir        = ir_reg;
    assign fetch_err = fetch_err_reg;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit. Each fetch pushes its expected
// outcome into a queue; a monitor pops and checks it whenever ir_valid is
// seen. A behavioural memory answers mem_rd after a programmable delay.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int ADDR_W = 16;

    typedef struct {
        logic [15:0]       ir;
        int                rd_cycles;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fetch_req = 1'b0;
    logic              pc_inc = 1'b0;
    logic              pc_load = 1'b0;
    logic [ADDR_W-1:0] pc_target = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ack = 1'b0;
    logic [15:0]       mem_rdata = '0;
    logic [15:0]       ir;
    logic              ir_valid;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              fetch_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    // Memory model configuration: ack after ack_delay cycles of mem_rd,
    // negative means never.
    int          ack_delay = -1;
    logic [15:0] mem_word  = '0;

    instr_fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_req (fetch_req),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .pc        (pc),
        .busy      (busy),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // -----------------------------------------------------------------------
    // Memory responder
    // -----------------------------------------------------------------------
    initial begin
        int cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_rd) begin
                if (ack_delay >= 0 && cyc == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 16'hDEAD;
                end
                cyc++;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'hBEEF;
                cyc       = 0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Monitor: counts request cycles, tracks address stability, and checks
    // each ir_valid pulse against the scoreboard.
    // -----------------------------------------------------------------------
    initial begin
        int                rd_cnt;
        logic              addr_stable;
        logic [ADDR_W-1:0] first_addr;
        exp_t              e;
        rd_cnt      = 0;
        addr_stable = 1'b1;
        first_addr  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_cnt      = 0;
                addr_stable = 1'b1;
            end else begin
                if (mem_rd) begin
                    if (rd_cnt == 0) first_addr = mem_addr;
                    else if (mem_addr !== first_addr) addr_stable = 1'b0;
                    rd_cnt++;
                end
                if (ir_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ir_valid", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_ir", 32'(ir), 32'(e.ir));
                        check("sb_rd_cycles", 32'(rd_cnt), 32'(e.rd_cycles));
                        check("sb_mem_addr", 32'(first_addr), 32'(e.addr));
                        check("sb_addr_stable", 32'(addr_stable), 32'd1);
                        check("sb_fetch_err", 32'(fetch_err), 32'(e.err));
                    end
                    rd_cnt      = 0;
                    addr_stable = 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic pulse_fetch();
        @(posedge clk); #1 fetch_req = 1'b1;
        @(posedge clk); #1 fetch_req = 1'b0;
    endtask

    task automatic load_pc(input logic [ADDR_W-1:0] target);
        @(posedge clk); #1 pc_load = 1'b1; pc_target = target;
        @(posedge clk); #1 pc_load = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({name, "_wait_bound"}, 32'd1, 32'd0);
    endtask

    task automatic do_fetch(input string name, input int delay, input logic [15:0] word,
                            input int rd_cycles, input logic [15:0] exp_ir,
                            input logic [ADDR_W-1:0] exp_addr, input logic exp_err);
        exp_t e;
        ack_delay   = delay;
        mem_word    = word;
        e.ir        = exp_ir;
        e.rd_cycles = rd_cycles;
        e.addr      = exp_addr;
        e.err       = exp_err;
        exp_q.push_back(e);
        pulse_fetch();
        wait_idle(name);
    endtask

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Main sequence
    // -----------------------------------------------------------------------
    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_pc", 32'(pc), 32'h0);
        check("reset_ir", 32'(ir), 32'h0);
        check("reset_mem_rd", 32'(mem_rd), 32'h0);
        check("reset_mem_addr", 32'(mem_addr), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_ir_valid", 32'(ir_valid), 32'h0);
        check("reset_fetch_err", 32'(fetch_err), 32'h0);

        // Reset during WAIT aborts: mem_rd drops at once, no IR capture.
        ack_delay = -1;
        pulse_fetch();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_mem_rd", 32'(mem_rd), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_ir", 32'(ir), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'h0);

        // Zero-wait fetch with explicit latency check.
        ack_delay = 0;
        mem_word  = 16'h5103;
        begin
            exp_t e;
            e.ir = 16'h5103; e.rd_cycles = 1; e.addr = 16'h0000; e.err = 1'b0;
            exp_q.push_back(e);
        end
        pulse_fetch();                  // edge N sampled fetch_req; now in ISSUE
        @(negedge clk);
        check("zw_issue_mem_rd", 32'(mem_rd), 32'h1);
        @(negedge clk);
        check("zw_ir_valid_cycle2", 32'(ir_valid), 32'h1);
        check("zw_ir", 32'(ir), 32'h5103);
        @(negedge clk);
        check("zw_busy_cycle3", 32'(busy), 32'h0);
        check("zw_ir_valid_low", 32'(ir_valid), 32'h0);

        // Three-cycle-wait fetch from 0x0004.
        load_pc(16'h0004);
        do_fetch("wait3", 3, 16'h0A51, 4, 16'h0A51, 16'h0004, 1'b0);
        check("wait3_ir_hold", 32'(ir), 32'h0A51);

        // Timeout from 0x0010, with a PC load and a stray fetch_req mid-WAIT.
        load_pc(16'h0010);
        begin
            exp_t e;
            e.ir = 16'h0000; e.rd_cycles = 16; e.addr = 16'h0010; e.err = 1'b1;
            exp_q.push_back(e);
        end
        ack_delay = -1;
        pulse_fetch();
        repeat (3) @(posedge clk);
        #1 pc_load = 1'b1; pc_target = 16'h0080;
        @(posedge clk); #1 pc_load = 1'b0;
        repeat (2) @(posedge clk);
        #1 fetch_req = 1'b1;
        @(posedge clk); #1 fetch_req = 1'b0;
        wait_idle("timeout");
        check("timeout_fetch_err", 32'(fetch_err), 32'h1);
        check("timeout_pc_loaded", 32'(pc), 32'h0080);
        repeat (3) @(negedge clk);
        check("no_second_fetch_busy", 32'(busy), 32'h0);

        // Successful fetch afterwards: error stays sticky.
        do_fetch("after_err", 1, 16'h1234, 2, 16'h1234, 16'h0080, 1'b1);

        // PC wrap and priority.
        load_pc(16'hFFFF);
        @(posedge clk); #1 pc_inc = 1'b1;
        @(posedge clk); #1 pc_inc = 1'b0;
        check("pc_wrap", 32'(pc), 32'h0000);
        @(posedge clk); #1 pc_inc = 1'b1; pc_load = 1'b1; pc_target = 16'h0040;
        @(posedge clk); #1 pc_inc = 1'b0; pc_load = 1'b0;
        check("pc_load_priority", 32'(pc), 32'h0040);
        @(posedge clk); #1 pc_inc = 1'b1;
        @(posedge clk); #1 pc_inc = 1'b0;
        check("pc_inc", 32'(pc), 32'h0041);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_instr_fetch_unit
